mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, meaning the RAM read latency in cycles (legal values 1..4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ReqValid, input, 1 bit: CPU access request valid.
REQ-005 SHALL have port ReqReady, output, 1 bit: unit can accept a request.
REQ-006 SHALL have port ReqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port ReqSize, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port ReqSigned, input, 1 bit: load sign-extension select.
REQ-009 SHALL have port ReqAddr, input, 8 bits: byte address.
REQ-010 SHALL have port ReqData, input, 32 bits: store data, right-justified.
REQ-011 SHALL have port RespValid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port RespData, output, 32 bits: load result; 0 for stores and errors.
REQ-013 SHALL have port RespError, output, 1 bit: request rejected, with no RAM access.
REQ-014 SHALL have ports Enable, ReadWrite, Address[7:0], DataIn[31:0], Size[1:0] as outputs driving the ram256x8 ports of the same names.
REQ-015 SHALL have port DataOut, input, 32 bits: ram256x8 read data, right-justified.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP and ERR; every output SHALL be registered.
REQ-017 SHALL assert ReqReady only in IDLE, and a request SHALL be accepted on an edge where ReqValid=1 and ReqReady=1.
REQ-018 SHALL latch ReqWrite, ReqSize, ReqSigned, ReqAddr and ReqData on acceptance, so that later changes to the request inputs have no effect.
REQ-019 SHALL detect an error at acceptance when any of the following holds:
- ReqSize=11;
- halfword with ReqAddr[0]=1;
- word with ReqAddr[1:0]!=00.
REQ-020 SHALL, on an error, go IDLE->ERR and then IDLE; ERR SHALL assert RespValid=1, RespError=1 and RespData=0 for exactly one cycle, with Enable held 0 throughout.
REQ-021 SHALL, on a legal store, go IDLE->ACCESS for exactly 1 cycle with the following outputs:
- Enable=1, ReadWrite=1;
- Address and Size set to the latched values;
- DataIn set to the latched data masked to the access size (bits above the size forced to 0).
REQ-022 SHALL, on a legal load, hold ACCESS for READ_LAT cycles with Enable=1 and ReadWrite=0, using an internal counter from READ_LAT-1 down to 0, and SHALL sample DataOut on the edge that leaves ACCESS.
REQ-023 SHALL extend load data by size:
- byte: bits[7:0], sign-extended from bit 7 if ReqSigned=1, else zero-extended;
- halfword: bits[15:0], extended from bit 15 by the same rule;
- word: passed unchanged.
REQ-024 SHALL assert RESP for exactly one cycle (RespValid=1, RespError=0, RespData set to the extended result or 0 for a store) and then return to IDLE.
REQ-025 SHALL have fixed latency from the acceptance edge to the RespValid cycle: load = READ_LAT+1 cycles, store = 2 cycles, error = 1 cycle.
REQ-026 SHALL drive Enable=0, ReadWrite=0, Address=0, DataIn=0 and Size=00 in every state other than ACCESS.
REQ-027 SHALL accept no new request while in ACCESS, RESP or ERR; the earliest back-to-back acceptance is the cycle after RESP or ERR.
REQ-028 SHALL permit address wrap-around: no address arithmetic is performed, so address 252 with a word access is legal.

Reset
REQ-029 SHALL, while reset=1, asynchronously force state IDLE, clear the counter and drive every output to 0, including ReqReady.
REQ-030 SHALL raise ReqReady to 1 on the first clk edge after reset deasserts.
REQ-031 SHALL, on reset asserted during ACCESS, drop Enable immediately, abort the access and produce no RespValid.

Verification
REQ-032 Store word 0x33445566 to address 12, then load word from address 12 -> RespData=0x33445566; store RespValid 2 cycles after acceptance; load RespValid READ_LAT+1 cycles after acceptance.
REQ-033 Store byte 0xA6 to address 0; load signed byte from 0 -> 0xFFFFFFA6; load unsigned byte from 0 -> 0x000000A6.
REQ-034 Store halfword 0xABCD to address 4 and 0xEF01 to address 6; load unsigned word from 4 -> 0xEF01ABCD under the RAM's byte ordering; load signed halfword from 4 -> 0xFFFFABCD.
REQ-035 Halfword load at address 5, word store at address 2, and ReqSize=11 -> each gives RespError=1 and RespData=0 one cycle after acceptance, with Enable never asserted.
REQ-036 With READ_LAT=3: load at address 0, assert reset on the second ACCESS cycle -> Enable=0 immediately, no RespValid, ReqReady=1 one edge after reset release.
REQ-037 Hold ReqValid=1 continuously with alternating store/load requests -> each request is accepted only when ReqReady=1, and no two accesses overlap.

Source files
------------

// File: rtl/mem_access_unit.sv
// CPU-side load/store sequencer for a ram256x8: checks alignment, drives the RAM
// for one store cycle or READ_LAT load cycles, then returns one registered response.
module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [7:0]  ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespError,
  output logic        Enable,
  output logic        ReadWrite,
  output logic [7:0]  Address,
  output logic [31:0] DataIn,
  output logic [1:0]  Size,
  input  logic [31:0] DataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} stateType;

  stateType    state, nextState;
  logic [1:0]  count;
  logic        latWrite, latSigned;
  logic [1:0]  latSize;
  logic [7:0]  latAddr;
  logic [31:0] latData;

  logic        accept, illegal;
  logic        nextReady, nextEnable, nextReadWrite, nextRespValid, nextRespError;
  logic [7:0]  nextAddress;
  logic [31:0] nextDataIn, nextRespData;
  logic [1:0]  nextSize;

  function automatic logic [31:0] maskData(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   maskData = {24'b0, d[7:0]};
      2'b01:   maskData = {16'b0, d[15:0]};
      default: maskData = d;
    endcase
  endfunction

  function automatic logic [31:0] extendData(input logic [31:0] d, input logic [1:0] sz,
                                             input logic sgn);
    case (sz)
      2'b00:   extendData = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   extendData = {{16{sgn & d[15]}}, d[15:0]};
      default: extendData = d;
    endcase
  endfunction

  assign accept  = (state == IDLE) && ReqValid && ReqReady;
  assign illegal = (ReqSize == 2'b11) ||
                   ((ReqSize == 2'b01) && ReqAddr[0]) ||
                   ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));

  // Outputs are computed one cycle ahead from the next state so every port is a flop;
  // on acceptance the raw request is used because the latches only load on that edge.
  always_comb begin
    nextState     = state;
    nextReady     = 1'b0;
    nextEnable    = 1'b0;
    nextReadWrite = 1'b0;
    nextAddress   = 8'd0;
    nextDataIn    = 32'd0;
    nextSize      = 2'b00;
    nextRespValid = 1'b0;
    nextRespError = 1'b0;
    nextRespData  = 32'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            nextState     = ERR;
            nextRespValid = 1'b1;
            nextRespError = 1'b1;
          end else begin
            nextState     = ACCESS;
            nextEnable    = 1'b1;
            nextReadWrite = ReqWrite;
            nextAddress   = ReqAddr;
            nextSize      = ReqSize;
            nextDataIn    = ReqWrite ? maskData(ReqData, ReqSize) : 32'd0;
          end
        end else begin
          nextReady = 1'b1;
        end
      end
      ACCESS: begin
        if (latWrite || (count == 2'd0)) begin
          nextState     = RESP;
          nextRespValid = 1'b1;
          nextRespData  = latWrite ? 32'd0 : extendData(DataOut, latSize, latSigned);
        end else begin
          nextEnable    = 1'b1;
          nextReadWrite = latWrite;
          nextAddress   = latAddr;
          nextSize      = latSize;
          nextDataIn    = latWrite ? maskData(latData, latSize) : 32'd0;
        end
      end
      RESP, ERR: begin
        nextState = IDLE;
        nextReady = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  // State, request latches and the load-latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 2'd0;
      latWrite  <= 1'b0;
      latSigned <= 1'b0;
      latSize   <= 2'b00;
      latAddr   <= 8'd0;
      latData   <= 32'd0;
    end else begin
      state <= nextState;
      if (accept) begin
        latWrite  <= ReqWrite;
        latSigned <= ReqSigned;
        latSize   <= ReqSize;
        latAddr   <= ReqAddr;
        latData   <= ReqData;
        count     <= 2'(READ_LAT - 1);
      end else if ((state == ACCESS) && (count != 2'd0)) begin
        count <= count - 2'd1;
      end
    end
  end

  // Registered outputs; reset clears them at once, which also aborts a RAM access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReqReady  <= 1'b0;
      Enable    <= 1'b0;
      ReadWrite <= 1'b0;
      Address   <= 8'd0;
      DataIn    <= 32'd0;
      Size      <= 2'b00;
      RespValid <= 1'b0;
      RespError <= 1'b0;
      RespData  <= 32'd0;
    end else begin
      ReqReady  <= nextReady;
      Enable    <= nextEnable;
      ReadWrite <= nextReadWrite;
      Address   <= nextAddress;
      DataIn    <= nextDataIn;
      Size      <= nextSize;
      RespValid <= nextRespValid;
      RespError <= nextRespError;
      RespData  <= nextRespData;
    end
  end

endmodule
